// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine: SPI master clock and framing engine.
// Generates SPI_SCLK in all four CPOL/CPHA modes from a runtime half-period divider,
// frames the transfer with SPI_CS_N setup/hold guard times, counts completed bits and
// issues sample/shift strobes that line up with the corresponding SCLK edge.
//
// state  | meaning
// IDLE   | CS_N high, SCLK parked at the latched idle level, waiting for start
// SETUP  | CS_N low, waiting CS_SETUP clocks before the first half-period
// ACTIVE | half-period counter running, SCLK toggles at terminal count
// HOLD   | SCLK parked at cpol, CS_N still low for CS_HOLD clocks, then done
module spi_sclk_engine #(
    parameter int DIV_W    = 16,
    parameter int CNT_W    = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] half_div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [CNT_W-1:0] num_bits,
    output logic             busy,
    output logic             done,
    output logic             SPI_SCLK,
    output logic             SPI_CS_N,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic [CNT_W-1:0] CLOCK_CYCLES
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [DIV_W-1:0] SETUP_TC = DIV_W'(CS_SETUP - 1);
    localparam logic [DIV_W-1:0] HOLD_TC  = DIV_W'(CS_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_div_q, half_div_d;
    logic [CNT_W-1:0] num_bits_q, num_bits_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic [CNT_W:0]   edge_nxt, total_edges;
    logic             cpol_q, cpol_d, cpha_q, cpha_d;
    logic             sclk_q, sclk_d, csn_q, csn_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             sample_q, sample_d, shift_q, shift_d;
    logic             leading, final_edge;

    // Edge bookkeeping: edges are numbered from 1, odd numbers are leading edges.
    assign edge_nxt    = edge_q + 1'b1;
    assign total_edges = {num_bits_q, 1'b0};
    assign leading     = ~edge_q[0];
    assign final_edge  = (edge_nxt == total_edges);

    // Next-state logic for the framing FSM and all registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_div_d = half_div_q;
        num_bits_d = num_bits_q;
        ccnt_d     = ccnt_q;
        edge_d     = edge_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        csn_d      = csn_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sample_d   = 1'b0;
        shift_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                sclk_d = cpol_q;
                csn_d  = 1'b1;
                if (start && (num_bits != '0)) begin
                    half_div_d = half_div;
                    num_bits_d = num_bits;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    sclk_d     = cpol;
                    csn_d      = 1'b0;
                    busy_d     = 1'b1;
                    ccnt_d     = '0;
                    edge_d     = '0;
                    cnt_d      = '0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    sclk_d  = cpol_q;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == SETUP_TC) begin
                    cnt_d   = '0;
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                // abort wins over a toggle due in the same cycle; that edge is dropped
                if (abort) begin
                    sclk_d  = cpol_q;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == half_div_q) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    if (leading) begin
                        sample_d = ~cpha_q;
                        shift_d  = cpha_q;
                    end else begin
                        ccnt_d   = ccnt_q + 1'b1;
                        sample_d = cpha_q;
                        // in mode CPHA=0 there is no bit left to shift after the last edge
                        shift_d  = ~cpha_q & ~final_edge;
                    end
                    if (final_edge) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                sclk_d = cpol_q;
                if (cnt_q == HOLD_TC) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            half_div_q <= '0;
            num_bits_q <= '0;
            ccnt_q     <= '0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            csn_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sample_q   <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_div_q <= half_div_d;
            num_bits_q <= num_bits_d;
            ccnt_q     <= ccnt_d;
            edge_q     <= edge_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            csn_q      <= csn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sample_q   <= sample_d;
            shift_q    <= shift_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign SPI_SCLK     = sclk_q;
    assign SPI_CS_N     = csn_q;
    assign sample_stb   = sample_q;
    assign shift_stb    = shift_q;
    assign CLOCK_CYCLES = ccnt_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: drives frames (directed and random), scrambles inputs
// mid-frame, and compares every output each cycle against a timing model computed
// from edge arithmetic.
module tb_spi_sclk_engine;

    localparam int DIV_W    = 16;
    localparam int CNT_W    = 8;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic             system_clock = 1'b0;
    logic             reset, start, abort, cpol, cpha;
    logic [DIV_W-1:0] half_div;
    logic [CNT_W-1:0] num_bits;
    logic             busy, done, SPI_SCLK, SPI_CS_N, sample_stb, shift_stb;
    logic [CNT_W-1:0] CLOCK_CYCLES;

    int n_total = 0;
    int n_bad   = 0;
    int m_hd, m_pol, m_pha, m_nb, m_abort;
    int idle_pol = 0;
    int idle_cc  = 0;
    int cnt_smp, cnt_sft;

    spi_sclk_engine #(
        .DIV_W(DIV_W), .CNT_W(CNT_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
    ) dut (
        .system_clock(system_clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .half_div(half_div),
        .cpol(cpol),
        .cpha(cpha),
        .num_bits(num_bits),
        .busy(busy),
        .done(done),
        .SPI_SCLK(SPI_SCLK),
        .SPI_CS_N(SPI_CS_N),
        .sample_stb(sample_stb),
        .shift_stb(shift_stb),
        .CLOCK_CYCLES(CLOCK_CYCLES)
    );

    always #5 system_clock = ~system_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle (relative to the start-sampling edge) of the last SCLK edge of the current frame.
    function automatic int last_edge();
        return CS_SETUP + m_hd + 2 + (2 * m_nb - 1) * (m_hd + 1);
    endfunction

    function automatic bit aborted();
        return (m_abort > 0) && (m_abort < last_edge());
    endfunction

    // Cycle at which done pulses and CS_N rises.
    function automatic int frame_end();
        return aborted() ? m_abort + 1 + CS_HOLD : last_edge() + CS_HOLD;
    endfunction

    // Expected outputs t cycles after the start-sampling edge.
    task automatic model(input int t, output int es, output int ec, output int eb,
                         output int ed, output int esm, output int esf, output int ecc);
        int p, t0, lim, d, m, k;
        p   = m_hd + 1;
        t0  = CS_SETUP + m_hd + 2;
        lim = aborted() ? m_abort : last_edge();
        d   = frame_end();
        m   = 0;
        if (t >= t0 && lim >= t0) m = (((t < lim) ? t : lim) - t0) / p + 1;
        es = m_pol ^ (m % 2);
        if (aborted() && t > m_abort) es = m_pol;
        esm = 0;
        esf = 0;
        if (t >= t0 && t <= lim && ((t - t0) % p) == 0) begin
            k = (t - t0) / p + 1;
            if (k % 2 == 1) begin
                if (m_pha != 0) esf = 1; else esm = 1;
            end else begin
                if (m_pha != 0) esm = 1;
                else if (k != 2 * m_nb) esf = 1;
            end
        end
        ecc = m / 2;
        if (t < d) begin
            eb = 1; ec = 0; ed = 0;
        end else if (t == d) begin
            eb = 0; ec = 1; ed = 1;
        end else begin
            eb = 0; ec = 1; ed = 0;
        end
    endtask

    task automatic compare_all(input string pfx, input int es, input int ec, input int eb,
                               input int ed, input int esm, input int esf, input int ecc);
        chk({pfx, "_sclk"}, SPI_SCLK, es);
        chk({pfx, "_csn"}, SPI_CS_N, ec);
        chk({pfx, "_busy"}, busy, eb);
        chk({pfx, "_done"}, done, ed);
        chk({pfx, "_smp"}, sample_stb, esm);
        chk({pfx, "_sft"}, shift_stb, esf);
        chk({pfx, "_cc"}, CLOCK_CYCLES, ecc);
    endtask

    // One frame: start at cycle 0, optional abort at cycle ab, optional reset at cycle rst_at.
    task automatic run_frame(input string pfx, input int hd, input int pol, input int pha,
                             input int nb, input int ab, input int rst_at, input bit scramble);
        int d, last, es, ec, eb, ed, esm, esf, ecc;
        m_hd = hd; m_pol = pol; m_pha = pha; m_nb = nb; m_abort = ab;
        d    = frame_end();
        last = (rst_at != 0) ? rst_at + 3 : d + 2;
        half_div = DIV_W'(hd);
        cpol     = pol[0];
        cpha     = pha[0];
        num_bits = CNT_W'(nb);
        start    = 1'b1;
        abort    = 1'b0;
        cnt_smp  = 0;
        cnt_sft  = 0;
        for (int t = 1; t <= last; t++) begin
            @(posedge system_clock);
            #1;
            if (rst_at != 0 && t > rst_at) begin
                es = 0; ec = 1; eb = 0; ed = 0; esm = 0; esf = 0; ecc = 0;
            end else begin
                model(t, es, ec, eb, ed, esm, esf, ecc);
            end
            compare_all(pfx, es, ec, eb, ed, esm, esf, ecc);
            cnt_smp += int'(sample_stb);
            cnt_sft += int'(shift_stb);
            start = 1'b0;
            abort = (t == ab);
            reset = (rst_at != 0 && t == rst_at);
            if (scramble) begin
                half_div = DIV_W'($urandom);
                cpol     = 1'($urandom_range(0, 1));
                cpha     = 1'($urandom_range(0, 1));
                num_bits = CNT_W'($urandom);
                if (t < d && !(rst_at != 0 && t >= rst_at))
                    start = ($urandom_range(0, 7) == 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        if (rst_at != 0) begin
            idle_pol = 0;
            idle_cc  = 0;
        end else begin
            model(d + 1, es, ec, eb, ed, esm, esf, ecc);
            idle_pol = pol;
            idle_cc  = ecc;
        end
    endtask

    initial begin
        int p, t0, l, d, ab, rst_at, hd, nb;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        half_div = '0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        num_bits = '0;
        repeat (3) @(posedge system_clock);
        #1;
        compare_all("rst", 0, 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge system_clock);
        #1;

        // mode 0, half_div=2, 8 bits
        run_frame("t1", 2, 0, 0, 8, 0, 0, 1'b1);
        chk("t1_nsmp", cnt_smp, 8);
        chk("t1_nsft", cnt_sft, 7);
        chk("t1_cc_final", CLOCK_CYCLES, 8);

        // mode 3, half_div=0, single bit
        run_frame("t2", 0, 1, 1, 1, 0, 0, 1'b1);
        chk("t2_nsmp", cnt_smp, 1);
        chk("t2_nsft", cnt_sft, 1);

        // start with num_bits=0 is ignored
        half_div = 16'd1;
        cpol     = ~idle_pol[0];
        cpha     = 1'b1;
        num_bits = '0;
        start    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge system_clock);
            #1;
            start = 1'b0;
            compare_all("t3", idle_pol, 1, 0, 0, 0, 0, idle_cc);
        end

        // mode 1, abort one cycle after the 3rd trailing edge (edge 6 at cycle 15)
        run_frame("t4", 1, 0, 1, 16, 16, 0, 1'b1);
        chk("t4_cc_final", CLOCK_CYCLES, 3);

        // reset in mid-ACTIVE
        run_frame("t5", 2, 1, 0, 6, 0, 20, 1'b1);

        // full-width bit count, no wrap
        run_frame("t7", 0, 0, 0, 255, 0, 0, 1'b0);
        chk("t7_cc_final", CLOCK_CYCLES, 255);

        for (int i = 0; i < 40; i++) begin
            hd = $urandom_range(0, 3);
            nb = $urandom_range(1, 12);
            p  = hd + 1;
            t0 = CS_SETUP + hd + 2;
            l  = t0 + (2 * nb - 1) * p;
            d  = l + CS_HOLD;
            ab = 0;
            rst_at = 0;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, l + 1);
            else if ($urandom_range(0, 9) == 0) rst_at = $urandom_range(1, d - 1);
            run_frame("rnd", hd, $urandom_range(0, 1), $urandom_range(0, 1), nb, ab, rst_at, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
